// File: rtl/interrupt_fetch_injector.sv
// Fetch-side interrupt sequencer: waits for a safe instruction boundary, freezes the PC
// and replaces the fetched stream with a bubble plus the two-word interrupt opcode pair.
module interrupt_fetch_injector #(
    parameter int          PC_W     = 16,
    parameter logic [2:0]  IMM_FUNC = 3'b100,
    parameter logic [15:0] NOP_WORD = 16'h07F8,
    parameter logic [15:0] INT_W1   = 16'hF480,
    parameter logic [15:0] INT_W2   = 16'hF500
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            int_req,
    input  logic            stall_in,
    input  logic [15:0]     fetch_instr,
    input  logic [PC_W-1:0] fetch_pc,
    output logic [15:0]     instr_out,
    output logic            pc_hold,
    output logic [PC_W-1:0] saved_pc,
    output logic            int_active,
    output logic            int_ack
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_IMM = 3'd1;
    localparam logic [2:0] S_BUBBLE   = 3'd2;
    localparam logic [2:0] S_INJ1     = 3'd3;
    localparam logic [2:0] S_INJ2     = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_sync_d;
    logic            r_pending;
    logic            w_pending_next;
    logic [PC_W-1:0] r_saved_pc;
    logic            r_int_ack;
    logic            w_edge;
    logic            w_is_imm;

    // The synchroniser never stalls, so an edge seen during a stall is still latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= int_req;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_edge   = r_sync2 & ~r_sync_d;
    assign w_is_imm = (fetch_instr[15:13] == IMM_FUNC);

    // A fresh edge in the INJ2 cycle beats the clear, giving back-to-back service.
    always_comb begin
        w_pending_next = r_pending | w_edge;
        if (!stall_in && (r_state == S_INJ2)) begin
            w_pending_next = w_edge;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!stall_in) begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending && w_is_imm) begin
                        w_next_state = S_WAIT_IMM;
                    end else if (r_pending) begin
                        w_next_state = S_BUBBLE;
                    end
                end
                S_WAIT_IMM: w_next_state = S_BUBBLE;
                S_BUBBLE:   w_next_state = S_INJ1;
                S_INJ1:     w_next_state = S_INJ2;
                S_INJ2:     w_next_state = S_IDLE;
                default:    w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pending  <= 1'b0;
            r_saved_pc <= '0;
            r_int_ack  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_next;
            r_int_ack <= !stall_in && (r_state == S_INJ2);
            if (!stall_in && (r_state == S_BUBBLE)) begin
                r_saved_pc <= fetch_pc;
            end
        end
    end

    // The word discarded in BUBBLE is re-fetched from saved_pc on return.
    always_comb begin
        instr_out  = fetch_instr;
        pc_hold    = 1'b0;
        int_active = 1'b0;
        case (r_state)
            S_WAIT_IMM: begin
                int_active = 1'b1;
            end
            S_BUBBLE: begin
                instr_out  = NOP_WORD;
                pc_hold    = 1'b1;
                int_active = 1'b1;
            end
            S_INJ1: begin
                instr_out  = INT_W1;
                pc_hold    = 1'b1;
                int_active = 1'b1;
            end
            S_INJ2: begin
                instr_out  = INT_W2;
                pc_hold    = 1'b1;
                int_active = 1'b1;
            end
            default: begin
                instr_out  = fetch_instr;
            end
        endcase
    end

    assign saved_pc = r_saved_pc;
    assign int_ack  = r_int_ack;

endmodule

// File: tb/tb_interrupt_fetch_injector.sv
// Directed self-checking bench for interrupt_fetch_injector: reset, single-word and
// two-word triggers, stalls, back-to-back service and merged edges.
module tb_interrupt_fetch_injector;

   logic        clk;
   logic        rst_n;
   logic        intReq;
   logic        stallIn;
   logic [15:0] fetchInstr;
   logic [15:0] fetchPc;
   logic [15:0] instrOut;
   logic        pcHold;
   logic [15:0] savedPc;
   logic        intActive;
   logic        intAck;

   int checks;
   int failures;

   interrupt_fetch_injector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .int_req     (intReq),
      .stall_in    (stallIn),
      .fetch_instr (fetchInstr),
      .fetch_pc    (fetchPc),
      .instr_out   (instrOut),
      .pc_hold     (pcHold),
      .saved_pc    (savedPc),
      .int_active  (intActive),
      .int_ack     (intAck)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one fetched word and its address, then let combinational outputs settle.
   task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc);
      fetchInstr = instr;
      fetchPc    = pc;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Linear directed sequence; each block is one scenario with hand-counted clock edges.
   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      intReq     = 1'b0;
      stallIn    = 1'b0;
      fetchInstr = 16'h1234;
      fetchPc    = 16'h0000;
      #3;
      checkOutput("rst_instr", 32'(instrOut), 32'h1234);
      checkOutput("rst_hold", 32'(pcHold), 32'h0);
      checkOutput("rst_active", 32'(intActive), 32'h0);
      checkOutput("rst_ack", 32'(intAck), 32'h0);
      checkOutput("rst_saved", 32'(savedPc), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();

      // Single-word trigger: pending after 3 edges, then NOP/F480/F500.
      intReq = 1'b1;
      tick(); tick(); tick();
      applyStimulus(16'h1000, 16'h001F);
      checkOutput("s_idle_instr", 32'(instrOut), 32'h1000);
      checkOutput("s_idle_hold", 32'(pcHold), 32'h0);
      checkOutput("s_idle_active", 32'(intActive), 32'h0);
      intReq = 1'b0;
      tick();
      applyStimulus(16'h1111, 16'h0020);
      checkOutput("s_bubble_instr", 32'(instrOut), 32'h07F8);
      checkOutput("s_bubble_hold", 32'(pcHold), 32'h1);
      checkOutput("s_bubble_active", 32'(intActive), 32'h1);
      tick();
      checkOutput("s_inj1_instr", 32'(instrOut), 32'hF480);
      checkOutput("s_inj1_hold", 32'(pcHold), 32'h1);
      checkOutput("s_saved", 32'(savedPc), 32'h0020);
      tick();
      checkOutput("s_inj2_instr", 32'(instrOut), 32'hF500);
      checkOutput("s_inj2_hold", 32'(pcHold), 32'h1);
      checkOutput("s_inj2_ack", 32'(intAck), 32'h0);
      tick();
      checkOutput("s_resume_instr", 32'(instrOut), 32'h1111);
      checkOutput("s_resume_hold", 32'(pcHold), 32'h0);
      checkOutput("s_resume_active", 32'(intActive), 32'h0);
      checkOutput("s_ack", 32'(intAck), 32'h1);
      tick();
      checkOutput("s_ack_drop", 32'(intAck), 32'h0);

      // Two-word boundary: opcode and immediate pass before the bubble.
      intReq = 1'b1;
      tick(); tick(); tick();
      applyStimulus(16'h8123, 16'h0030);
      checkOutput("w_opc_instr", 32'(instrOut), 32'h8123);
      checkOutput("w_opc_hold", 32'(pcHold), 32'h0);
      intReq = 1'b0;
      tick();
      applyStimulus(16'hBEEF, 16'h0031);
      checkOutput("w_imm_instr", 32'(instrOut), 32'hBEEF);
      checkOutput("w_imm_hold", 32'(pcHold), 32'h0);
      checkOutput("w_imm_active", 32'(intActive), 32'h1);
      tick();
      applyStimulus(16'h2222, 16'h0032);
      checkOutput("w_bubble_instr", 32'(instrOut), 32'h07F8);
      tick();
      checkOutput("w_inj1_instr", 32'(instrOut), 32'hF480);
      checkOutput("w_saved", 32'(savedPc), 32'h0032);
      tick();
      checkOutput("w_inj2_instr", 32'(instrOut), 32'hF500);
      tick();
      checkOutput("w_ack", 32'(intAck), 32'h1);
      checkOutput("w_resume_active", 32'(intActive), 32'h0);

      // Stall held across two edges while in INJ1.
      intReq = 1'b1;
      tick(); tick(); tick();
      intReq = 1'b0;
      tick();
      checkOutput("t_bubble_instr", 32'(instrOut), 32'h07F8);
      tick();
      stallIn = 1'b1;
      #1;
      checkOutput("t_inj1_a", 32'(instrOut), 32'hF480);
      tick();
      checkOutput("t_inj1_b", 32'(instrOut), 32'hF480);
      checkOutput("t_stall_hold", 32'(pcHold), 32'h1);
      tick();
      checkOutput("t_inj1_c", 32'(instrOut), 32'hF480);
      checkOutput("t_stall_ack", 32'(intAck), 32'h0);
      stallIn = 1'b0;
      #1;
      tick();
      checkOutput("t_inj2_instr", 32'(instrOut), 32'hF500);
      tick();
      checkOutput("t_ack", 32'(intAck), 32'h1);
      tick();
      checkOutput("t_ack_once", 32'(intAck), 32'h0);
      checkOutput("t_idle_active", 32'(intActive), 32'h0);

      // New edge landing in the INJ2 cycle keeps pending for back-to-back service.
      intReq = 1'b1;
      tick(); tick(); tick();
      intReq = 1'b0;
      tick();
      intReq = 1'b1;
      checkOutput("b_bubble1", 32'(instrOut), 32'h07F8);
      tick();
      checkOutput("b_inj1", 32'(instrOut), 32'hF480);
      tick();
      checkOutput("b_inj2", 32'(instrOut), 32'hF500);
      tick();
      checkOutput("b_reentry_ack", 32'(intAck), 32'h1);
      checkOutput("b_reentry_active", 32'(intActive), 32'h0);
      tick();
      checkOutput("b_bubble2", 32'(instrOut), 32'h07F8);
      checkOutput("b_bubble2_ack", 32'(intAck), 32'h0);
      tick();
      checkOutput("b_inj1_2", 32'(instrOut), 32'hF480);
      tick();
      checkOutput("b_inj2_2", 32'(instrOut), 32'hF500);
      tick();
      checkOutput("b_ack2", 32'(intAck), 32'h1);
      tick();
      checkOutput("b_done_active", 32'(intActive), 32'h0);

      // Two edges two clocks apart merge into one sequence.
      intReq = 1'b0;
      tick(); tick(); tick();
      intReq = 1'b1;
      tick();
      intReq = 1'b0;
      tick();
      intReq = 1'b1;
      tick();
      checkOutput("m_idle_active", 32'(intActive), 32'h0);
      tick();
      checkOutput("m_bubble", 32'(instrOut), 32'h07F8);
      tick();
      checkOutput("m_inj1", 32'(instrOut), 32'hF480);
      tick();
      checkOutput("m_inj2", 32'(instrOut), 32'hF500);
      tick();
      checkOutput("m_ack", 32'(intAck), 32'h1);
      tick();
      checkOutput("m_after_active", 32'(intActive), 32'h0);
      checkOutput("m_after_ack", 32'(intAck), 32'h0);
      tick();
      checkOutput("m_after2_active", 32'(intActive), 32'h0);
      checkOutput("m_after2_hold", 32'(pcHold), 32'h0);

      // Reset asserted mid-INJ1 drops the sequence and the pending request.
      intReq = 1'b0;
      tick(); tick(); tick();
      intReq = 1'b1;
      tick(); tick(); tick();
      tick();
      tick();
      applyStimulus(16'h3456, 16'h0040);
      checkOutput("r_inj1", 32'(instrOut), 32'hF480);
      intReq = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("r_instr", 32'(instrOut), 32'h3456);
      checkOutput("r_hold", 32'(pcHold), 32'h0);
      checkOutput("r_active", 32'(intActive), 32'h0);
      checkOutput("r_ack", 32'(intAck), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick(); tick();
      checkOutput("r_lost_active", 32'(intActive), 32'h0);
      checkOutput("r_lost_hold", 32'(pcHold), 32'h0);
      checkOutput("r_lost_instr", 32'(instrOut), 32'h3456);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
